cpu_step_controller: RTL



---
 rtl/cpu_step_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_step_controller.sv
// Single-step / run / breakpoint controller for a soft CPU. It gates the CPU
// with a one-cycle advance pulse and sequences a timed CPU reset.
module cpu_step_controller #(
  parameter int DIV_W      = 20,
  parameter int RST_CYCLES = 4
) (
  input  logic        sys_Clock,
  input  logic        Reset,
  input  logic        step_btn,
  input  logic        run_btn,
  input  logic        cpu_rst_btn,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  output logic        cpu_clk_en,
  output logic        cpu_reset,
  output logic [2:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_RUN  = 3'd2,
    S_BRK  = 3'd3,
    S_CRST = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic             skip_q, skip_d;
  logic [15:0]      instr_count_q, count_d;
  logic             clk_en_d, cpu_reset_d;
  logic             step_prev, run_prev, rst_prev;
  logic             step_edge, run_edge, rst_edge;
  logic             tick_wrap, bp_hit;

  assign step_edge = step_btn & ~step_prev;
  assign run_edge  = run_btn & ~run_prev;
  assign rst_edge  = cpu_rst_btn & ~rst_prev;

  // One advance opportunity per 2^DIV_W cycles spent in RUN.
  assign tick_wrap = (state_q == S_RUN) && (tick_q == '1);
  // skip_q lets the instruction we stopped on execute once after resuming.
  assign bp_hit    = tick_wrap && bp_en && (pc == bp_addr) && !skip_q;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    skip_d   = skip_q;
    count_d  = instr_count_q;
    clk_en_d = 1'b0;
    tick_d   = (state_q == S_RUN) ? tick_q + 1'b1 : '0;

    if (rst_edge) begin
      state_d = S_CRST;
      hold_d  = HOLD_INIT;
      count_d = '0;
      skip_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_edge) begin
            state_d = S_RUN;
            skip_d  = 1'b0;
          end else if (step_edge) begin
            state_d  = S_STEP;
            clk_en_d = 1'b1;
            count_d  = instr_count_q + 1'b1;
          end
        end
        S_STEP: state_d = S_IDLE;
        S_RUN: begin
          if (run_edge) begin
            state_d = S_IDLE;
          end else if (tick_wrap) begin
            skip_d = 1'b0;
            if (bp_hit) begin
              state_d = S_BRK;
            end else begin
              clk_en_d = 1'b1;
              count_d  = instr_count_q + 1'b1;
            end
          end
        end
        S_BRK: begin
          if (run_edge) begin
            state_d = S_RUN;
            skip_d  = 1'b1;
          end else if (step_edge) begin
            state_d  = S_STEP;
            clk_en_d = 1'b1;
            count_d  = instr_count_q + 1'b1;
          end
        end
        S_CRST: begin
          hold_d = hold_q - 1'b1;
          if (hold_q <= 8'd1) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_CRST;
          hold_d  = HOLD_INIT;
        end
      endcase
    end

    cpu_reset_d = (state_d == S_CRST);
  end

  always_ff @(posedge sys_Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_CRST;
      hold_q        <= HOLD_INIT;
      tick_q        <= '0;
      skip_q        <= 1'b0;
      instr_count_q <= '0;
      step_prev     <= 1'b0;
      run_prev      <= 1'b0;
      rst_prev      <= 1'b0;
      cpu_clk_en    <= 1'b0;
      cpu_reset     <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      tick_q        <= tick_d;
      skip_q        <= skip_d;
      instr_count_q <= count_d;
      step_prev     <= step_btn;
      run_prev      <= run_btn;
      rst_prev      <= cpu_rst_btn;
      cpu_clk_en    <= clk_en_d & ~cpu_reset_d;
      cpu_reset     <= cpu_reset_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == S_BRK);
  assign instr_count = instr_count_q;

endmodule
